// File: rtl/load_pkg.sv
// Shared definitions for the load path: load type encoding (funct3),
// controller state encoding, doubleword offset width, and the alignment
// rule for each access size.
package load_pkg;

    localparam int DWORD_OFFSET_BITS = 3;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LD  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        LWU = 3'd6
    } load_type_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } load_state_t;

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [2:0] ltype,
                                           input logic [DWORD_OFFSET_BITS-1:0] off);
        case (ltype)
            LH, LHU: return off[0];
            LW, LWU: return |off[1:0];
            LD:      return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extender.sv
// Lane select plus sign/zero extension of an aligned doubleword.
// Purely combinational.
//   data   : aligned 64-bit word read from memory
//   lane   : byte offset of the access inside the doubleword
//   ltype  : load type (selects field width and signedness)
//   result : extended 64-bit load value
module load_extender
    import load_pkg::*;
(
    input  logic [63:0]                  data,
    input  logic [DWORD_OFFSET_BITS-1:0] lane,
    input  load_type_t                   ltype,
    output logic [63:0]                  result
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;
    logic [31:0] word_f;

    always_comb begin
        byte_f = data[{lane, 3'b000} +: 8];
        half_f = data[{lane[2:1], 4'b0000} +: 16];
        word_f = data[{lane[2], 5'b00000} +: 32];

        case (ltype)
            LB:      result = {{56{byte_f[7]}}, byte_f};
            LH:      result = {{48{half_f[15]}}, half_f};
            LW:      result = {{32{word_f[31]}}, word_f};
            LBU:     result = {56'd0, byte_f};
            LHU:     result = {48'd0, half_f};
            LWU:     result = {32'd0, word_f};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts a load from the MEM stage, issues one aligned 64-bit
// read over a request/grant/valid handshake, and returns the addressed
// field extended to 64 bits. Stalls the pipeline while the read is in flight.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   LoadReq/Type/Addr     : load request from MEM (sampled in IDLE only)
//   MemRd, MemAddr        : read request and aligned address to data memory
//   MemGnt                : memory accepts the request
//   MemRValid, MemDataIn  : read data return
//   LoadResult            : extended data, held until the next completion
//   LoadDone, LoadErr     : one-cycle completion / error pulses
//   Busy                  : pipeline stall
//
// state  | meaning
// IDLE   | waiting for LoadReq; misaligned/reserved loads go straight to ERR
// REQ    | MemRd high until granted (data may return with the grant)
// WAIT   | granted, waiting for MemRValid
// DONE   | LoadDone pulse, LoadResult valid
// ERR    | LoadErr pulse (bad access or timeout)
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadReq,
    input  logic [2:0]  LoadType,
    input  logic [63:0] LoadAddr,
    output logic        MemRd,
    output logic [63:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [63:0] MemDataIn,
    output logic [63:0] LoadResult,
    output logic        LoadDone,
    output logic        LoadErr,
    output logic        Busy
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    load_state_t                  state_q, state_d;
    load_type_t                   type_q;
    logic [DWORD_OFFSET_BITS-1:0] lane_q;
    logic [CW-1:0]                cnt_q;
    logic [63:0]                  ext_data;

    logic bad_access;
    logic accept;
    logic capture;
    logic timed_out;

    assign bad_access = (LoadType == 3'd7) ||
                        is_misaligned(LoadType, LoadAddr[DWORD_OFFSET_BITS-1:0]);
    assign accept     = (state_q == S_IDLE) && LoadReq && !bad_access;

    // Data returning in the same cycle as the grant is taken directly.
    assign capture    = ((state_q == S_REQ) && MemGnt && MemRValid) ||
                        ((state_q == S_WAIT) && MemRValid);

    // Last allowed cycle of REQ/WAIT; a capture in this cycle still wins.
    assign timed_out  = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        MemRd    = 1'b0;
        LoadDone = 1'b0;
        LoadErr  = 1'b0;
        Busy     = 1'b0;

        case (state_q)
            S_IDLE: begin
                Busy = LoadReq;
                if (LoadReq) begin
                    state_d = bad_access ? S_ERR : S_REQ;
                end
            end
            S_REQ: begin
                MemRd = 1'b1;
                Busy  = 1'b1;
                if (capture) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else if (MemGnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                Busy = 1'b1;
                if (capture) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                LoadDone = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERR: begin
                LoadErr = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            type_q     <= LB;
            lane_q     <= '0;
            MemAddr    <= '0;
            LoadResult <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                type_q  <= load_type_t'(LoadType);
                lane_q  <= LoadAddr[DWORD_OFFSET_BITS-1:0];
                MemAddr <= {LoadAddr[63:DWORD_OFFSET_BITS], {DWORD_OFFSET_BITS{1'b0}}};
            end
            if (capture) begin
                LoadResult <= ext_data;
            end
            // Held at zero outside REQ/WAIT, so it is clear on entry to REQ.
            if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
                cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    load_extender u_extender (
        .data   (MemDataIn),
        .lane   (lane_q),
        .ltype  (type_q),
        .result (ext_data)
    );

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit. The driver computes, from the access rules,
// the cycle and content of every completion/error pulse plus per-cycle
// MemRd/Busy/MemAddr/LoadResult expectations and queues them; a monitor
// on the falling edge pops and compares whatever the DUT presents.
module tb_load_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        LoadReq = 1'b0;
    logic [2:0]  LoadType = '0;
    logic [63:0] LoadAddr = '0;
    logic        MemRd;
    logic [63:0] MemAddr;
    logic        MemGnt = 1'b0;
    logic        MemRValid = 1'b0;
    logic [63:0] MemDataIn = '0;
    logic [63:0] LoadResult;
    logic        LoadDone;
    logic        LoadErr;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] last_res = '0;

    typedef struct {
        int          cyc;
        bit          err;
        logic [63:0] res;
    } pulse_t;

    typedef struct {
        int          cyc;
        bit          memrd;
        bit          busy;
        bit          chk_addr;
        logic [63:0] addr;
        logic [63:0] res;
    } ctrl_t;

    pulse_t pq[$];
    ctrl_t  cq[$];
    pulse_t p;
    ctrl_t  c;

    load_unit #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadReq    (LoadReq),
        .LoadType   (LoadType),
        .LoadAddr   (LoadAddr),
        .MemRd      (MemRd),
        .MemAddr    (MemAddr),
        .MemGnt     (MemGnt),
        .MemRValid  (MemRValid),
        .MemDataIn  (MemDataIn),
        .LoadResult (LoadResult),
        .LoadDone   (LoadDone),
        .LoadErr    (LoadErr),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: shift the addressed bytes down, mask to size, extend.
    function automatic logic [63:0] ref_load(input logic [2:0] lt, input logic [63:0] addr,
                                             input logic [63:0] data);
        int nbytes;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        nbytes = 1 << int'(lt[1:0]);
        off    = int'(addr[2:0]);
        v      = data >> (8 * off);
        if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            v    = v & mask;
            if (lt < 3'd4 && v[8 * nbytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit ref_bad(input logic [2:0] lt, input logic [63:0] addr);
        int nbytes;
        nbytes = 1 << int'(lt[1:0]);
        return (lt == 3'd7) || ((int'(addr[2:0]) % nbytes) != 0);
    endfunction

    // One load. gnt/val are cycle numbers relative to acceptance (0 = never).
    task automatic run_load(input logic [2:0] lt, input logic [63:0] addr, input logic [63:0] data,
                            input int gnt, input int val, input int idle);
        int lat;
        int req_end;
        bit err;
        bit bad;
        logic [63:0] prev;
        logic [63:0] newres;
        ctrl_t ce;
        pulse_t pe;
        prev = last_res;
        bad  = ref_bad(lt, addr);
        if (bad) begin
            lat = 1; err = 1'b1; newres = prev; req_end = 0;
        end else begin
            req_end = (gnt >= 1 && gnt <= T) ? gnt : T;
            if (gnt >= 1 && gnt <= T && val >= gnt && val <= T) begin
                lat = val + 1; err = 1'b0; newres = ref_load(lt, addr, data);
            end else begin
                lat = T + 1; err = 1'b1; newres = prev;
            end
        end
        for (int k = 0; k <= lat + idle; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                LoadReq = 1'b1; LoadType = lt; LoadAddr = addr;
                pe.cyc = cyc + lat; pe.err = err; pe.res = newres;
                pq.push_back(pe);
            end else if (k <= lat) begin
                LoadReq  = 1'($urandom_range(0, 1));
                LoadType = 3'($urandom_range(0, 7));
                LoadAddr = {$urandom, $urandom};
            end else begin
                LoadReq = 1'b0;
            end
            MemGnt    = (k == gnt) || (k > lat && $urandom_range(0, 3) == 0);
            MemRValid = (val != 0 && k == val) || (k > lat && $urandom_range(0, 3) == 0);
            MemDataIn = (val != 0 && k == val) ? data : {$urandom, $urandom};
            ce.cyc      = cyc;
            ce.memrd    = (k >= 1 && k <= req_end);
            ce.busy     = (k < lat);
            ce.chk_addr = ce.memrd;
            ce.addr     = {addr[63:3], 3'b000};
            ce.res      = (k >= lat) ? newres : prev;
            cq.push_back(ce);
        end
        last_res = newres;
    endtask

    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            p = pq.pop_front();
            chk("missing_pulse_cycle", 64'(cyc), 64'(p.cyc));
        end
        if (LoadDone || LoadErr) begin
            chk("pulse_exclusive", {63'd0, LoadDone & LoadErr}, 64'd0);
            if (pq.size() > 0 && pq[0].cyc == cyc) begin
                p = pq.pop_front();
                chk("LoadErr", {63'd0, LoadErr}, {63'd0, p.err});
                chk("LoadDone", {63'd0, LoadDone}, {63'd0, !p.err});
                chk("LoadResult_pulse", LoadResult, p.res);
            end else begin
                chk("unexpected_pulse", {62'd0, LoadDone, LoadErr}, 64'd0);
            end
        end
        while (cq.size() > 0 && cq[0].cyc < cyc) void'(cq.pop_front());
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            c = cq.pop_front();
            chk("MemRd", {63'd0, MemRd}, {63'd0, c.memrd});
            chk("Busy", {63'd0, Busy}, {63'd0, c.busy});
            chk("LoadResult_held", LoadResult, c.res);
            if (c.chk_addr) chk("MemAddr", MemAddr, c.addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_t ce;
        logic [2:0]  lt;
        logic [63:0] addr;
        int gnt;
        int val;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        ce.cyc = cyc; ce.memrd = 1'b0; ce.busy = 1'b0; ce.chk_addr = 1'b1;
        ce.addr = 64'd0; ce.res = 64'd0;
        cq.push_back(ce);

        // LB, zero-latency memory
        run_load(3'd0, 64'h1005, 64'h0011_8000_0000_0000, 1, 1, 1);
        // LHU, valid three cycles after grant
        run_load(3'd5, 64'h2006, 64'h8001_0000_0000_0000, 1, 4, 1);
        // misaligned LW
        run_load(3'd2, 64'h3002, 64'h1234_5678_9ABC_DEF0, 0, 0, 1);
        // timeout with a late response afterwards
        run_load(3'd2, 64'h6000, 64'h0000_0000_1111_2222, 1, T + 2, 2);
        // back-to-back LD then LW
        run_load(3'd3, 64'h4000, 64'h8765_4321_DEAD_BEEF, 1, 2, 0);
        run_load(3'd2, 64'h4004, 64'h8765_4321_DEAD_BEEF, 1, 1, 1);

        // reset while in WAIT, then stray valids
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            #1;
            LoadReq   = (k == 0);
            LoadType  = 3'd3;
            LoadAddr  = 64'h5008;
            MemGnt    = (k == 1);
            MemRValid = (k >= 3);
            MemDataIn = 64'hCAFE_F00D_0000_0001;
            reset     = (k == 2);
            ce.cyc      = cyc;
            ce.memrd    = (k == 1);
            ce.busy     = (k <= 2);
            ce.chk_addr = (k == 1) || (k >= 3);
            ce.addr     = (k == 1) ? 64'h5008 : 64'd0;
            ce.res      = (k >= 3) ? 64'd0 : last_res;
            cq.push_back(ce);
        end
        last_res = 64'd0;
        MemRValid = 1'b0;

        // randomized loads
        for (int n = 0; n < 60; n++) begin
            lt   = 3'($urandom_range(0, 7));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << int'(lt[1:0])) - 1);
            gnt = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 6));
            val = ($urandom_range(0, 9) == 0) ? 0 : gnt + int'($urandom_range(0, 3));
            run_load(lt, addr, {$urandom, $urandom}, gnt, val, int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pending_pulses", 64'(pq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Memory-read counterpart of the store-data merge path: accepts a load from the MEM stage, issues one aligned 64-bit read to data memory over a request/grant/valid handshake, and returns the addressed byte, half, word or doubleword sign- or zero-extended to 64 bits. It stalls the pipeline while the read is in flight, and flags misaligned accesses, reserved types and memory timeouts.

## Interface
- `TIMEOUT`, default 255: cycles allowed from the `MemGnt` request phase through `MemRValid` before the load is aborted.
- `clk` in 1: clock.
- `reset` in 1: synchronous reset, active-high.
- `LoadReq` in 1: load request from the MEM stage, sampled in IDLE only.
- `LoadType` in 3: funct3 of the load. 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU, 7 reserved.
- `LoadAddr` in 64: byte address.
- `MemRd` out 1: read request to data memory.
- `MemAddr` out 64: `{LoadAddr[63:3], 3'b000}`, held stable while `MemRd` is high.
- `MemGnt` in 1: memory accepts the request.
- `MemRValid` in 1: `MemDataIn` is valid.
- `MemDataIn` in 64: aligned doubleword read from memory.
- `LoadResult` out 64: extended load data, held until the next completion.
- `LoadDone` out 1: one-cycle completion pulse.
- `LoadErr` out 1: one-cycle error pulse (misaligned, reserved type, or timeout).
- `Busy` out 1: pipeline stall.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- **IDLE**
  - `LoadReq=1` with a reserved type, or with a misaligned address, goes to ERR. Misaligned means LH/LHU with `addr[0]`≠0, LW/LWU with `addr[1:0]`≠0, or LD with `addr[2:0]`≠0. No memory request is issued.
  - Any other `LoadReq=1` latches `LoadType`, `LoadAddr[2:0]` and `MemAddr`, then goes to REQ.
- **REQ**
  - `MemRd=1`.
  - `MemGnt=1` goes to WAIT.
  - `MemGnt=1` together with `MemRValid=1` captures data and goes straight to DONE.
- **WAIT**
  - `MemRd=0`.
  - `MemRValid=1` captures data and goes to DONE.
- **DONE**
  - `LoadDone=1`, then IDLE.
- **ERR**
  - `LoadErr=1`, then IDLE.
- **Timeout counter**
  - Cleared on entry to REQ and incremented each cycle spent in REQ or WAIT.
  - Reaching `TIMEOUT` without capturing data goes to ERR. `LoadResult` is unchanged and `MemRd` drops.
- **Extraction**, with lane = latched `addr[2:0]`:
  - Byte: `MemDataIn[8*lane +: 8]`.
  - Half: `MemDataIn[16*lane[2:1] +: 16]`.
  - Word: `MemDataIn[32*lane[2] +: 32]`.
  - Double: all 64 bits.
- **Extension**
  - LB/LH/LW sign-extend from the MSB of the field.
  - LBU/LHU/LWU zero-extend.
  - LD passes the data through.
- **Registering**: `LoadResult` is registered at capture and is valid in the DONE cycle.
- **Ignored inputs**
  - `LoadReq` outside IDLE is ignored; the pipeline holds it while `Busy`.
  - `MemRValid` outside REQ/WAIT is ignored, including a late response after a timeout.

## Timing
- **Reset values**: state IDLE, `MemRd=0`, `MemAddr=0`, `LoadResult=0`, `LoadDone=0`, `LoadErr=0`, `Busy=0`, counter 0.
- **Reset mid-operation**: the next cycle is IDLE, `MemRd` is deasserted, and no `LoadDone` is produced.
- **Busy**
  - Combinational: equals `LoadReq` in IDLE.
  - High in REQ and WAIT.
  - Low in DONE and ERR, so the pipeline advances in the same cycle as the pulse.
- **Minimum latency**, with request accepted at cycle 0:
  - `MemRd` high at cycle 1.
  - `MemGnt` and `MemRValid` both high at cycle 1 gives `LoadDone` at cycle 2.
- **General latency**: a grant at cycle g and valid at cycle v > g gives `LoadDone` at cycle v+1.
- **Error latency**: an error detected at acceptance (cycle 0) gives `LoadErr` at cycle 1.
- **Pulse exclusivity**: `LoadDone` and `LoadErr` are never high together.
- **Back-to-back loads**: a new load can be accepted in the cycle after DONE or ERR.

## Structure
- Shared package `load_pkg` holds:
  - `typedef enum logic [2:0]` for `load_type_t` (LB..LWU, values as above).
  - `typedef enum` for `load_state_t`.
  - Constant `DWORD_OFFSET_BITS = 3`.
- Sub-module `load_extender`: purely combinational lane select plus sign/zero extension. Inputs are data, lane and type; output is 64 bits. It is instantiated once before the `LoadResult` register.

## Test plan
- **LB, zero-latency memory.** LB at addr 0x1005, `MemDataIn`=0x0011_8000_0000_0000, `MemGnt`/`MemRValid` both high at cycle 1. Lane 5 holds byte 0x80. Required: `LoadResult`=0xFFFF_FFFF_FFFF_FF80, `LoadDone` at cycle 2, `MemAddr`=0x1000.
- **LHU, delayed valid.** LHU at addr 0x2006, `MemDataIn`=0x8001_0000_0000_0000, grant at cycle 1, valid at cycle 4. Required: `LoadResult`=0x0000_0000_0000_8001, `LoadDone` at cycle 5, `Busy` high in cycles 0–4.
- **Misaligned LW.** LW at addr 0x3002. Required: `LoadErr` at cycle 1, `MemRd` never asserted, `LoadResult` unchanged.
- **Timeout.** `TIMEOUT`=4, `MemGnt` at cycle 1, `MemRValid` never asserted. Required: `LoadErr` pulse, `MemRd` low afterwards. A `MemRValid` arriving after the timeout does not raise `LoadDone`.
- **Reset in WAIT.** Assert `reset` while in WAIT. Required: IDLE next cycle, all outputs at reset values. A later `MemRValid` is ignored.
- **Back-to-back loads.** LD at 0x4000 followed by LW at 0x4004, data 0x8765_4321_DEAD_BEEF each time. Required: first `LoadResult`=0x8765_4321_DEAD_BEEF, second = 0xFFFF_FFFF_8765_4321, second accepted in the cycle after the first `LoadDone`.
